// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding and stream framing.
package loader_pkg;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] ST_HDR_LO = 3'd0;
  localparam logic [2:0] ST_HDR_HI = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_LAST   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;
  localparam logic [2:0] ST_CHK    = 3'd6;

endpackage

// File: rtl/word_assembler.sv
// Shifts payload bytes into a little-endian 32-bit word; word_done flags the 4th byte of a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [31:0] word_q;
  logic [1:0]  cnt;

  // Shift right so the first byte of a word ends up in bits 7:0.
  assign word_next = {byte_data, word_q[31:8]};
  assign word_done = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt    <= '0;
    end else if (byte_en) begin
      word_q <= word_next;
      cnt    <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// HDR_LO | waiting for word-count low byte
// HDR_HI | waiting for word-count high byte, range check
// DATA   | accepting payload bytes
// LAST   | final word being written
// CHK    | waiting for checksum byte (checksum builds only)
// DONE   | load complete, core released (terminal)
// ERR    | load aborted (terminal)
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] DEPTH_W = DEPTH;

  logic [2:0]       state;
  logic [7:0]       n_lo;
  logic [HDR_W-1:0] n_words;
  logic [HDR_W-1:0] idx;
  logic [HDR_W-1:0] n_hdr;
  logic             hdr_ok;
  logic             xfer;
  logic             word_done;
  logic [31:0]      word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  always_comb begin
    byte_ready = 1'b0;
    if (!rst) begin
      byte_ready = (state == ST_HDR_LO) || (state == ST_HDR_HI) || (state == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == ST_CHK) byte_ready = 1'b1;
`endif
    end
  end

  assign xfer   = byte_valid && byte_ready;
  assign n_hdr  = {byte_data, n_lo};
  assign hdr_ok = (n_hdr != '0) && ({16'd0, n_hdr} <= DEPTH_W);

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .byte_en   (xfer && (state == ST_DATA)),
    .byte_data (byte_data),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR_LO;
      n_lo       <= '0;
      n_words    <= '0;
      idx        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_BASE;
      imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_HDR_LO: if (xfer) begin
          n_lo  <= byte_data;
          state <= ST_HDR_HI;
        end
        ST_HDR_HI: if (xfer) begin
          n_words <= n_hdr;
          state   <= hdr_ok ? ST_DATA : ST_ERR;
        end
        ST_DATA: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum <= sum + byte_data;
`endif
          if (word_done) begin
            imem_we    <= 1'b1;
            imem_wdata <= word_next;
            imem_addr  <= ADDR_BASE + 32'({idx, 2'b00});
            idx        <= idx + 1'b1;
            if (idx == n_words - 1'b1) state <= ST_LAST;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_LAST: state <= ST_CHK;
        ST_CHK: if (xfer) state <= (byte_data == sum) ? ST_DONE : ST_ERR;
`else
        ST_LAST: state <= ST_DONE;
`endif
        default: state <= state;
      endcase
    end
  end

  // Outputs decode directly from the state register so done and core_rst flip together.
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);
  assign core_rst = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes queued from a word-list model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, core_rst, done, error;
  logic [31:0] imem_addr, imem_wdata;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          last_we_cyc = -10;
  logic        done_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] word_q[$];
  logic [7:0]  stream_q[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the next queued expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) chk(1'b0, "unexpected_write", {imem_addr, imem_wdata}, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk({imem_addr, imem_wdata} == e, "write", {imem_addr, imem_wdata}, e);
      end
      last_we_cyc = cyc;
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (!rst && done && !done_prev)
      chk((cyc == last_we_cyc + 1) && !core_rst, "done_timing", 64'(cyc - last_we_cyc), 64'd1);
`endif
    done_prev = done;
  end

  // Model: header = count LE, payload = words LE, addresses ADDR_BASE + 4*i, trailer = byte sum.
  task automatic prep_stream();
    logic [7:0]  sum;
    logic [31:0] w;
    int          n;
    n = word_q.size();
    sum = 8'h00;
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = word_q[i];
      for (int b = 0; b < 4; b++) begin
        stream_q.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
      exp_q.push_back({32'(4 * i), w});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(sum);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int tries;
    while ($urandom_range(99) < stall) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    #1;
    while (!byte_ready) begin
      tries++;
      if (tries > 20) begin
        chk(1'b0, "ready_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input int stall);
    foreach (stream_q[i]) send_byte(stream_q[i], stall);
  endtask

  task automatic wait_end(input bit exp_done);
    int t;
    t = 0;
    while (!done && !error && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(done == exp_done && error == !exp_done, "end_state", {done, error}, {exp_done, !exp_done});
    chk(core_rst == !exp_done && byte_ready == 1'b0, "end_ctrl", {core_rst, byte_ready}, {!exp_done, 1'b0});
    chk(exp_q.size() == 0, "writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk(byte_ready == 1'b0 && imem_we == 1'b0 && imem_addr == 32'h0 && imem_wdata == 32'h0,
        "reset_datapath", {imem_we, byte_ready, imem_addr}, 64'd0);
    chk(core_rst == 1'b1 && done == 1'b0 && error == 1'b0, "reset_status",
        {core_rst, done, error}, 3'b100);
    rst = 1'b0;
    #1;
    chk(byte_ready == 1'b1, "ready_after_reset", byte_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic load_normal_words();
    word_q.delete();
    word_q.push_back(32'h00500513);
    word_q.push_back(32'h00A00593);
  endtask

  initial begin
    int n;
    do_reset();

    // Directed two-word load
    load_normal_words();
    prep_stream();
    send_stream(0);
    wait_end(1'b1);
    repeat (4) @(negedge clk);
    chk(done == 1'b1 && imem_we == 1'b0, "done_terminal", {done, imem_we}, 2'b10);

    // Zero count header
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk(error == 1'b1 && byte_ready == 1'b0 && core_rst == 1'b1, "zero_count",
        {error, byte_ready, core_rst}, 3'b101);
    wait_end(1'b0);

    // Count above DEPTH
    do_reset();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    wait_end(1'b0);

    // Count equal to DEPTH is legal
    do_reset();
    word_q.delete();
    for (int i = 0; i < 64; i++) word_q.push_back($urandom);
    prep_stream();
    send_stream(0);
    wait_end(1'b1);

    // Directed stream with ~50% stalls
    do_reset();
    load_normal_words();
    prep_stream();
    send_stream(50);
    wait_end(1'b1);

    // Reset after the 5th byte, then a clean reload
    do_reset();
    load_normal_words();
    prep_stream();
    for (int i = 0; i < 5; i++) send_byte(stream_q[i], 0);
    chk(exp_q.size() == 2, "no_early_write", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    do_reset();
    prep_stream();
    send_stream(0);
    wait_end(1'b1);

    // Random loads with random stall density
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(1, 8);
      word_q.delete();
      for (int i = 0; i < n; i++) word_q.push_back($urandom);
      prep_stream();
      send_stream($urandom_range(0, 60));
      wait_end(1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good trailer is A0 for the directed payload; A1 must abort
    do_reset();
    load_normal_words();
    prep_stream();
    chk(stream_q[stream_q.size()-1] == 8'hA0, "model_trailer", stream_q[stream_q.size()-1], 8'hA0);
    send_stream(0);
    wait_end(1'b1);
    do_reset();
    load_normal_words();
    prep_stream();
    stream_q[stream_q.size()-1] = 8'hA1;
    send_stream(0);
    wait_end(1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
